// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, key-index-to-code table and scanner state encodings shared with the calculator FSM
package keypad_pkg;
  typedef enum logic [3:0] {
    ST_SCAN = 4'b0001,
    ST_DEB  = 4'b0010,
    ST_HOLD = 4'b0100,
    ST_REL  = 4'b1000
  } state_t;
  localparam logic [7:0] CODE_PLUS  = 8'hF0;
  localparam logic [7:0] CODE_MINUS = 8'hF1;
  localparam logic [7:0] CODE_MUL   = 8'hF2;
  localparam logic [7:0] CODE_DIV   = 8'hF3;
  localparam logic [7:0] CODE_CLEAR = 8'hCC;
  localparam logic [7:0] CODE_EQU   = 8'hEE;
  localparam logic [7:0] CODE_NONE  = 8'hFF;
  localparam logic [15:0][7:0] KEY_MAP = {
    CODE_DIV,   CODE_EQU, 8'h00, CODE_CLEAR,
    CODE_MUL,   8'h09,    8'h08, 8'h07,
    CODE_MINUS, 8'h06,    8'h05, 8'h04,
    CODE_PLUS,  8'h03,    8'h02, 8'h01
  };
  function automatic logic [7:0] digit_code(input logic [3:0] n);
    return {4'h0, n};
  endfunction
endpackage

// File: rtl/keypad_keymap.sv
// keypad_keymap: combinational key index (row*4+col) to key code lookup
module keypad_keymap
  import keypad_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] code
);
  assign code = KEY_MAP[idx];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 column scanner with debounce; define KEYPAD_TWO_KEY_LOCKOUT_EN to reject multi-row samples
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [7:0] code,
  output logic       pressed
);
  import keypad_pkg::*;
  state_t      state, nxt_state;
  logic [15:0] div_cnt;
  logic [7:0]  cnt, key_code;
  logic [1:0]  col_idx, cand_row, smp_row;
  logic        tick, smp_vld, hit, cnt_done, clr_pend;
  keypad_keymap u_keymap (.idx({cand_row, col_idx}), .code(key_code));
  // resolve the row sample to one key row, or none
  always_comb begin
    tick     = div_cnt == 16'(SCAN_DIV - 1);
    smp_row  = !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;
`ifdef KEYPAD_TWO_KEY_LOCKOUT_EN
    smp_vld  = $countones(~row) == 1;
`else
    smp_vld  = ~&row;
`endif
    hit      = smp_vld && smp_row == cand_row;
    cnt_done = (cnt + 8'd1) == 8'(DEB_CNT);
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst ? ST_SCAN : nxt_state;
  // next state, evaluated only on the sampling clock of each window
  always_comb begin
    nxt_state = state;
    if (tick)
      case (state)
        ST_SCAN: nxt_state = smp_vld ? ST_DEB : ST_SCAN;
        ST_DEB:  nxt_state = !hit ? ST_SCAN : cnt_done ? ST_HOLD : ST_DEB;
        ST_HOLD: nxt_state = hit ? ST_HOLD : ST_REL;
        ST_REL:  nxt_state = hit ? ST_HOLD : cnt_done ? ST_SCAN : ST_REL;
        default: nxt_state = ST_SCAN;
      endcase
  end
  // window divider, column pointer, candidate, match/absent counter and code register
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt  <= '0;
      col_idx  <= '0;
      cand_row <= '0;
      cnt      <= '0;
      code     <= CODE_NONE;
      clr_pend <= 1'b0;
    end else begin
      div_cnt  <= tick ? '0 : div_cnt + 16'd1;
      clr_pend <= state == ST_REL && nxt_state == ST_SCAN;
      if (clr_pend)
        code <= CODE_NONE;
      if (state == ST_DEB && nxt_state == ST_HOLD)
        code <= key_code;
      if (tick) begin
        cnt <= (state == ST_SCAN || state == ST_HOLD) ? 8'd1 : cnt + 8'd1;
        if (state == ST_SCAN && smp_vld)
          cand_row <= smp_row;
        if (nxt_state == ST_SCAN)
          col_idx <= col_idx + 2'd1;
      end
    end
  end
  // column drive and pressed flag
  always_comb begin
    col     = ~(4'b0001 << col_idx);
    pressed = state == ST_HOLD || state == ST_REL;
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: vector table, corner sequences and random presses against a per-window keypad model
module tb_keypad_scanner;
  localparam int SD  = 4;
  localparam int DC  = 3;
  localparam int LAT = (3 + DC) * SD + 2;
  localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2, M_REL = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row, col;
  logic [7:0]  code;
  logic        pressed;
  logic [15:0] keys = '0;
  int          checks = 0, errors = 0;
  int          rises = 0, m_rises = 0;
  logic        prev_p = 1'b0, m_prev = 1'b0;
  string       legend = "123+456-789*C0=/";
  int          m_win, m_col, m_mode, m_cand, m_n;
  logic [7:0]  m_code;
  logic        m_pressed, m_clr;
  typedef struct {
    byte        ch;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[10];

  keypad_scanner #(.SCAN_DIV(SD), .DEB_CNT(DC)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .code(code), .pressed(pressed)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rows_for(logic [15:0] k, logic [3:0] c);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 16; i++)
      if (k[i] && !c[i % 4]) r[i / 4] = 1'b0;
    return r;
  endfunction
  assign row = rows_for(keys, col);

  function automatic int key_of(byte ch);
    for (int k = 0; k < 16; k++)
      if (legend[k] == ch) return k;
    return 0;
  endfunction

  function automatic logic [7:0] spec_code(int k);
    byte ch = legend[k];
    if (ch >= "0" && ch <= "9") return 8'(ch - "0");
    return ch == "+" ? 8'hF0 : ch == "-" ? 8'hF1 : ch == "*" ? 8'hF2 :
           ch == "/" ? 8'hF3 : ch == "C" ? 8'hCC : 8'hEE;
  endfunction

  function automatic int sample_key(logic [15:0] k, int c);
    int lows = 0, first = -1;
    for (int r = 0; r < 4; r++)
      if (k[r * 4 + c]) begin
        lows++;
        if (first < 0) first = r;
      end
`ifdef KEYPAD_TWO_KEY_LOCKOUT_EN
    if (lows > 1) return -1;
`endif
    return first < 0 ? -1 : first * 4 + c;
  endfunction

  task automatic model_step();
    int s;
    if (!rst) begin
      m_win = 0; m_col = 0; m_mode = M_SCAN; m_cand = 0; m_n = 0;
      m_code = 8'hFF; m_pressed = 1'b0; m_clr = 1'b0;
      return;
    end
    if (m_clr) begin
      m_code = 8'hFF;
      m_clr = 1'b0;
    end
    if (m_win != SD - 1) begin
      m_win++;
      return;
    end
    m_win = 0;
    s = sample_key(keys, m_col);
    case (m_mode)
      M_SCAN:
        if (s >= 0) begin m_cand = s; m_n = 1; m_mode = M_DEB; end
        else m_col = (m_col + 1) % 4;
      M_DEB:
        if (s == m_cand) begin
          m_n++;
          if (m_n == DC) begin m_mode = M_HOLD; m_pressed = 1'b1; m_code = spec_code(m_cand); end
        end else begin
          m_mode = M_SCAN; m_col = (m_col + 1) % 4;
        end
      M_HOLD:
        if (s != m_cand) begin m_mode = M_REL; m_n = 1; end
      default:
        if (s == m_cand) m_mode = M_HOLD;
        else begin
          m_n++;
          if (m_n == DC) begin m_mode = M_SCAN; m_pressed = 1'b0; m_clr = 1'b1; m_col = (m_col + 1) % 4; end
        end
    endcase
  endtask

  task automatic cmp();
    logic [3:0] mc = 4'hF ^ (4'b0001 << m_col);
    checks++;
    if (col !== mc || code !== m_code || pressed !== m_pressed) begin
      errors++;
      $display("FAIL model t=%0t col=%b/%b code=%h/%h pressed=%b/%b (actual/expected)",
               $time, col, mc, code, m_code, pressed, m_pressed);
    end
    if (pressed && !prev_p) rises++;
    prev_p = pressed;
    if (m_pressed && !m_prev) m_rises++;
    m_prev = m_pressed;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp();
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_p(logic lvl, int budget, string nm);
    int i = 0;
    while (pressed !== lvl && i < budget) begin
      cyc();
      i++;
    end
    chk(nm, 32'(pressed), 32'(lvl));
  endtask

  task automatic press_release(byte ch, logic [7:0] exp, int hold);
    int r0 = rises;
    keys = 16'(1) << key_of(ch);
    wait_p(1'b1, LAT, "press latency");
    chk("code on press", 32'(code), 32'(exp));
    repeat (hold) cyc();
    chk("code held", 32'(code), 32'(exp));
    keys = '0;
    wait_p(1'b0, 20, "release");
    chk("code at fall", 32'(code), 32'(exp));
    cyc();
    chk("code after fall", 32'(code), 32'hFF);
    chk("single pulse", 32'(rises - r0), 32'd1);
    repeat (3) cyc();
  endtask

  initial begin
    int r0, k, k2, hold, bnc;
    vecs = '{'{"3", 8'h03}, '{"5", 8'h05}, '{"+", 8'hF0}, '{"7", 8'h07}, '{"=", 8'hEE},
             '{"C", 8'hCC}, '{"0", 8'h00}, '{"/", 8'hF3}, '{"-", 8'hF1}, '{"*", 8'hF2}};
    repeat (3) cyc();
    chk("reset col", 32'(col), 32'hE);
    chk("reset code", 32'(code), 32'hFF);
    chk("reset pressed", 32'(pressed), 32'd0);
    rst = 1'b1;
    repeat (5) cyc();
    for (int i = 0; i < 10; i++)
      press_release(vecs[i].ch, vecs[i].exp, 6 * SD);
    r0 = rises;
    for (int i = 0; i < 40; i++) begin
      keys = ((i / 3) % 2 == 0) ? 16'(1) << key_of("=") : '0;
      cyc();
    end
    chk("bounce no pulse", 32'(rises - r0), 32'd0);
    keys = 16'(1) << key_of("=");
    wait_p(1'b1, LAT, "bounce press");
    chk("bounce code", 32'(code), 32'hEE);
    keys = '0;
    wait_p(1'b0, 20, "bounce release");
    chk("bounce pulses", 32'(rises - r0), 32'd1);
    repeat (3) cyc();
    r0 = rises;
    keys = 16'(1) << key_of("5");
    wait_p(1'b1, LAT, "glitch press");
    repeat (2 * SD) cyc();
    keys = '0;
    repeat (SD) cyc();
    keys = 16'(1) << key_of("5");
    repeat (3 * SD) cyc();
    chk("glitch held", 32'(pressed), 32'd1);
    chk("glitch pulses", 32'(rises - r0), 32'd1);
    keys = '0;
    wait_p(1'b0, 20, "glitch release");
    repeat (3) cyc();
    r0 = rises;
    keys = 16'h0011;
`ifdef KEYPAD_TWO_KEY_LOCKOUT_EN
    repeat (LAT + 8) cyc();
    chk("lockout pulses", 32'(rises - r0), 32'd0);
`else
    wait_p(1'b1, LAT, "two-key press");
    chk("two-key code", 32'(code), 32'h01);
`endif
    keys = '0;
    wait_p(1'b0, 20, "two-key release");
    repeat (3) cyc();
    keys = 16'(1) << key_of("C");
    wait_p(1'b1, LAT, "clear press");
    chk("clear code", 32'(code), 32'hCC);
    repeat (5) cyc();
    rst = 1'b0;
    keys = '0;
    cyc();
    chk("hold reset pressed", 32'(pressed), 32'd0);
    chk("hold reset code", 32'(code), 32'hFF);
    chk("hold reset col", 32'(col), 32'hE);
    rst = 1'b1;
    r0 = rises;
    repeat (30) cyc();
    chk("post reset pulses", 32'(rises - r0), 32'd0);
    repeat (25) begin
      k = $urandom_range(15);
      k2 = $urandom_range(15);
      hold = $urandom_range(60);
      bnc = $urandom_range(12);
      keys = '0;
      repeat ($urandom_range(12)) cyc();
      for (int i = 0; i < bnc; i++) begin
        keys = (i % 2 == 0) ? 16'(1) << k : '0;
        repeat ($urandom_range(5, 1)) cyc();
      end
      keys = 16'(1) << k;
      if ($urandom_range(3) == 0) keys[k2] = 1'b1;
      repeat (hold) cyc();
      keys = '0;
      repeat (20) cyc();
    end
    chk("total pulses", 32'(rises), 32'(m_rises));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks per column window, legal range 2..65535.
REQ-002 SHALL have parameter DEB_CNT, default 8: consecutive equal samples needed to accept a press or release, legal range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port row, input, 4 bits: keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, one-hot-low.
REQ-007 SHALL have port code, output, 8 bits: key code; 8'hFF when no key is valid.
REQ-008 SHALL have port pressed, output, 1 bit: high while a debounced key is held.

Function
REQ-009 SHALL map key index row*4+col, with r0 = 1 2 3 +, r1 = 4 5 6 -, r2 = 7 8 9 *, r3 = Clear 0 = /.
REQ-010 SHALL encode codes as: digit N -> 8'h0N; + -> F0; - -> F1; * -> F2; / -> F3; Clear -> CC; = -> EE.
REQ-011 SHALL use the FSM states SCAN, DEBOUNCE, HOLD and RELEASE, one-hot encoded.
REQ-012 SHALL sample row in SCAN only on the last clock of each SCAN_DIV window, after which col rotates 0->1->2->3->0.
REQ-013 SHALL, in SCAN, on a sample with any row low, latch the candidate (col,row), freeze col, set the match count to 1 and go to DEBOUNCE.
REQ-014 SHALL, in DEBOUNCE, sample once per window; a sample equal to the candidate increments the count; any other sample returns to SCAN with col advanced.
REQ-015 SHALL, when the count reaches DEB_CNT, enter HOLD and on the same edge load code from the map and set pressed=1.
REQ-016 SHALL, in HOLD, keep col frozen and code stable; a sample without the candidate goes to RELEASE with absent count 1.
REQ-017 SHALL, in RELEASE, return to HOLD on a sample with the candidate present; at DEB_CNT absent samples it SHALL set pressed=0 and go to SCAN.
REQ-018 SHALL hold code for exactly one clock after pressed falls, then set code=8'hFF, so a consumer acting on the pressed falling edge sees a valid code.
REQ-019 SHALL resolve more than one low row in a sample, without the macro, to the lowest row index.
REQ-020 SHALL never assert pressed for more than one key per press, and SHALL NOT auto-repeat.
REQ-021 SHALL assert pressed no later than (3+DEB_CNT)*SCAN_DIV+2 clocks after a clean, held press.

Reset
REQ-022 SHALL, while rst=0 at a clock edge, set state=SCAN, col=4'b1110, code=8'hFF, pressed=0 and clear all counters.
REQ-023 SHALL, on reset mid-HOLD, drop pressed within that clock with no further code pulse; scanning restarts at column 0.

Configuration
REQ-024 SHALL, with KEYPAD_TWO_KEY_LOCKOUT_EN defined, treat any sample with more than one low row as no key; in DEBOUNCE this returns to SCAN, in HOLD it counts as absent.
REQ-025 SHALL, without KEYPAD_TWO_KEY_LOCKOUT_EN, apply the lowest-row rule of REQ-019.

Structure
REQ-026 SHALL place the code constants (digits, operators, CODE_CLEAR=8'hCC, CODE_EQU=8'hEE, CODE_NONE=8'hFF) and the state encodings in shared package keypad_pkg, for use by the calculator FSM.
REQ-027 SHALL implement the key-index-to-code table as combinational sub-module keypad_keymap (4-bit in, 8-bit out).

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-028 SHALL cover: row=4'b1110 steady while col=4'b1011 (key "3") -> pressed rises, code=8'h03 through the whole hold; release -> code=8'hFF one clock after pressed falls.
REQ-029 SHALL cover: bounce on key "=" toggling every 3 clocks for 40 clocks then steady -> exactly one pressed pulse, code=8'hEE, no pulse during the bounce.
REQ-030 SHALL cover: "5", "+", "7", "=" pressed in sequence -> codes 05, F0, 07, EE, each with a single pressed pulse.
REQ-031 SHALL cover: keys "1" and "4" held together (column 0, rows 0 and 1) -> without macro code=8'h01; with macro, no pressed.
REQ-032 SHALL cover: rst=0 for 1 clock during HOLD of "Clear" -> next clock pressed=0, code=8'hFF, col=4'b1110.
REQ-033 SHALL cover: release glitch of 1 window inside HOLD (absent count < DEB_CNT) -> pressed stays high, no second pulse.
